// File: rtl/sparc_ifu_fetstg_pkg.sv
// Shared definitions for the fetch staging queue: word layout and the
// way-select classification used to decide hit / miss / multi-hit.
package sparc_ifu_fetstg_pkg;

    localparam int FST_DW      = 34;
    localparam int FST_PAR_BIT = 33;
    localparam int FST_SW_BIT  = 32;

    typedef enum logic [1:0] {
        WS_MISS = 2'b00,
        WS_HIT  = 2'b01,
        WS_MHIT = 2'b10
    } ws_class_e;

    // Zero bits set is a miss, exactly one is a hit, more than one is a multi-hit.
    function automatic ws_class_e ws_classify(input logic [3:0] waysel);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            ones += int'(waysel[i]);
        end
        if (ones == 0) begin
            return WS_MISS;
        end else if (ones == 1) begin
            return WS_HIT;
        end
        return WS_MHIT;
    endfunction

endpackage

// File: rtl/sparc_ifu_fstq.sv
// Generic DEPTH x W synchronous FIFO with flush. Head data is read straight
// from storage, so a pushed entry is visible no earlier than the next cycle.
module sparc_ifu_fstq #(
    parameter int DEPTH = 2,
    parameter int W     = 71
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; flush clears like reset.
    always_ff @(posedge clk) begin
        if (!rst_l || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sparc_ifu_fetstg.sv
// Fetch staging: classifies each s1 fetch by way-select, parity-checks the
// fetch and top words, and queues good fetches towards decode.
module sparc_ifu_fetstg
    import sparc_ifu_fetstg_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = FST_DW
) (
    input  logic          rclk,
    input  logic          rst_l,
    input  logic          fcl_fst_fetval_s1,
    input  logic [1:0]    fcl_fst_tid_s1,
    input  logic          fcl_fst_flush,
    input  logic [3:0]    itlb_wsel_waysel_s1,
    input  logic [DW-1:0] wsel_fdp_fetdata_s1,
    input  logic [DW-1:0] wsel_fdp_topdata_s1,
    input  logic          dtu_fst_ready,
    output logic          fst_fcl_stall,
    output logic          fst_fcl_icmiss_s2,
    output logic          fst_fcl_mhit_s2,
    output logic          fst_dtu_val_s2,
    output logic [DW-1:0] fst_dtu_inst_s2,
    output logic [DW-1:0] fst_dtu_top_s2,
    output logic [1:0]    fst_dtu_tid_s2,
    output logic          fst_dtu_perr_s2
);

    localparam int EW = 2 * DW + 3;

    ws_class_e      ws_class;
    logic           push;
    logic           pop;
    logic           perr_s1;
    logic           q_full;
    logic           q_empty;
    logic [EW-1:0]  q_din;
    logic [EW-1:0]  q_head;
    logic [DW-1:0]  head_inst;
    logic [DW-1:0]  head_top;
    logic [1:0]     head_tid;
    logic           head_perr;

    assign ws_class = ws_classify(itlb_wsel_waysel_s1);

    // Even parity across the whole word, parity bit included.
    assign perr_s1 = (^wsel_fdp_fetdata_s1) | (^wsel_fdp_topdata_s1);

    assign push = fcl_fst_fetval_s1 & (ws_class == WS_HIT) & ~fst_fcl_stall & ~fcl_fst_flush;
    assign pop  = fst_dtu_val_s2 & dtu_fst_ready & ~fcl_fst_flush;

    assign q_din = {fcl_fst_tid_s1, perr_s1, wsel_fdp_topdata_s1, wsel_fdp_fetdata_s1};
    assign {head_tid, head_perr, head_top, head_inst} = q_head;

    sparc_ifu_fstq #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fstq (
        .clk   (rclk),
        .rst_l (rst_l),
        .push  (push),
        .pop   (pop),
        .flush (fcl_fst_flush),
        .din   (q_din),
        .full  (q_full),
        .empty (q_empty),
        .head  (q_head)
    );

    // Stall comes only from registered occupancy, never from ready.
    assign fst_fcl_stall  = q_full;
    assign fst_dtu_val_s2 = ~q_empty;

    // Head fields are zeroed while the queue is empty so reset/idle outputs read 0.
    assign fst_dtu_inst_s2 = fst_dtu_val_s2 ? head_inst : '0;
    assign fst_dtu_top_s2  = fst_dtu_val_s2 ? head_top  : '0;
    assign fst_dtu_tid_s2  = fst_dtu_val_s2 ? head_tid  : '0;
    assign fst_dtu_perr_s2 = fst_dtu_val_s2 & head_perr;

    // One-cycle miss / multi-hit pulses, suppressed by flush.
    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            fst_fcl_icmiss_s2 <= 1'b0;
            fst_fcl_mhit_s2   <= 1'b0;
        end else begin
            fst_fcl_icmiss_s2 <= fcl_fst_fetval_s1 & (ws_class == WS_MISS) & ~fcl_fst_flush;
            fst_fcl_mhit_s2   <= fcl_fst_fetval_s1 & (ws_class == WS_MHIT) & ~fcl_fst_flush;
        end
    end

`ifdef DEFINE_0IN
    // fcl must hold off while the queue is full; such a fetch is dropped.
    fetch_while_stalled: assert property (@(posedge rclk) disable iff (!rst_l)
        !(fcl_fst_fetval_s1 && fst_fcl_stall));
`endif

endmodule

// File: tb/tb_sparc_ifu_fetstg.sv
// Directed bench for the fetch staging queue (DEPTH=2).
module tb_sparc_ifu_fetstg;

    logic        rclk;
    logic        rst_l;
    logic        fetval;
    logic [1:0]  tid;
    logic        flush;
    logic [3:0]  waysel;
    logic [33:0] fetdata;
    logic [33:0] topdata;
    logic        ready;
    logic        stall;
    logic        icmiss;
    logic        mhit;
    logic        val;
    logic [33:0] inst;
    logic [33:0] top;
    logic [1:0]  otid;
    logic        perr;

    int n_chk;
    int n_pass;

    sparc_ifu_fetstg #(.DEPTH(2), .DW(34)) dut (
        .rclk                (rclk),
        .rst_l               (rst_l),
        .fcl_fst_fetval_s1   (fetval),
        .fcl_fst_tid_s1      (tid),
        .fcl_fst_flush       (flush),
        .itlb_wsel_waysel_s1 (waysel),
        .wsel_fdp_fetdata_s1 (fetdata),
        .wsel_fdp_topdata_s1 (topdata),
        .dtu_fst_ready       (ready),
        .fst_fcl_stall       (stall),
        .fst_fcl_icmiss_s2   (icmiss),
        .fst_fcl_mhit_s2     (mhit),
        .fst_dtu_val_s2      (val),
        .fst_dtu_inst_s2     (inst),
        .fst_dtu_top_s2      (top),
        .fst_dtu_tid_s2      (otid),
        .fst_dtu_perr_s2     (perr)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Even-parity word: bit33 makes the total weight even.
    function automatic logic [33:0] mkw(input logic [31:0] d, input logic sw);
        return {^{sw, d}, sw, d};
    endfunction

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [3:0] ws, input logic [33:0] f,
                         input logic [33:0] t, input logic [1:0] id);
        fetval  = fv;
        waysel  = ws;
        fetdata = f;
        topdata = t;
        tid     = id;
    endtask

    task automatic check_head(input string tag, input logic v, input logic [33:0] i,
                              input logic [33:0] t, input logic [1:0] id, input logic pe);
        check_eq({tag, ".val"},  64'(val),  64'(v));
        check_eq({tag, ".inst"}, 64'(inst), 64'(i));
        check_eq({tag, ".top"},  64'(top),  64'(t));
        check_eq({tag, ".tid"},  64'(otid), 64'(id));
        check_eq({tag, ".perr"}, 64'(perr), 64'(pe));
    endtask

    logic [33:0] wa, wb, wc, tpa, bad_top;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_l  = 1'b0;
        flush  = 1'b0;
        ready  = 1'b0;
        // A miss presented during reset must not produce a pulse.
        drive(1'b1, 4'b0000, '0, '0, 2'd0);

        // 1. reset
        step();
        step();
        check_head("rst", 1'b0, '0, '0, 2'd0, 1'b0);
        check_eq("rst.stall",  64'(stall),  64'd0);
        check_eq("rst.icmiss", 64'(icmiss), 64'd0);
        check_eq("rst.mhit",   64'(mhit),   64'd0);
        drive(1'b0, 4'b0000, '0, '0, 2'd0);
        rst_l = 1'b1;
        step();
        check_eq("idle.val",   64'(val),   64'd0);
        check_eq("idle.stall", 64'(stall), 64'd0);

        // 2. hit stream with ready=1: one push and one pop per cycle
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wa  = mkw(32'h1234_5678 + 32'(i), i[0]);
            tpa = mkw(32'hcafe_0000 + 32'(i), 1'b0);
            drive(1'b1, 4'b0100, wa, tpa, 2'(i));
            step();
            check_head($sformatf("hit%0d", i), 1'b1, wa, tpa, 2'(i), 1'b0);
            check_eq($sformatf("hit%0d.stall", i), 64'(stall), 64'd0);
        end
        check_eq("hit0.word", 64'(mkw(32'h1234_5678, 1'b0)), 64'h2_1234_5678);
        drive(1'b0, 4'b0000, '0, '0, 2'd0);
        step();
        check_eq("drain.val", 64'(val), 64'd0);

        // 3. backpressure: fill, fcl holds the third, then drain in order
        ready = 1'b0;
        wa = mkw(32'haaaa_0001, 1'b0);
        wb = mkw(32'hbbbb_0002, 1'b1);
        wc = mkw(32'hcccc_0003, 1'b0);
        drive(1'b1, 4'b0001, wa, wa, 2'd1);
        step();
        check_eq("bp1.stall", 64'(stall), 64'd0);
        check_head("bp1", 1'b1, wa, wa, 2'd1, 1'b0);
        drive(1'b1, 4'b1000, wb, wb, 2'd2);
        step();
        check_eq("bp2.stall", 64'(stall), 64'd1);
        drive(1'b0, 4'b0000, '0, '0, 2'd0);
        step();
        check_head("bp_hold", 1'b1, wa, wa, 2'd1, 1'b0);
        check_eq("bp_hold.stall", 64'(stall), 64'd1);
        ready = 1'b1;
        step();
        check_eq("bp_pop1.stall", 64'(stall), 64'd0);
        check_head("bp_pop1", 1'b1, wb, wb, 2'd2, 1'b0);
        drive(1'b1, 4'b0010, wc, wc, 2'd3);
        step();
        check_head("bp_pop2", 1'b1, wc, wc, 2'd3, 1'b0);
        drive(1'b0, 4'b0000, '0, '0, 2'd0);
        step();
        check_eq("bp_empty.val", 64'(val), 64'd0);

        // 4. miss and multi-hit: pulses only, nothing queued
        drive(1'b1, 4'b0000, wa, wa, 2'd0);
        step();
        check_eq("miss.icmiss", 64'(icmiss), 64'd1);
        check_eq("miss.mhit",   64'(mhit),   64'd0);
        check_eq("miss.val",    64'(val),    64'd0);
        drive(1'b1, 4'b0011, wa, wa, 2'd0);
        step();
        check_eq("mh.icmiss", 64'(icmiss), 64'd0);
        check_eq("mh.mhit",   64'(mhit),   64'd1);
        check_eq("mh.val",    64'(val),    64'd0);
        drive(1'b1, 4'b1111, wa, wa, 2'd0);
        step();
        check_eq("mh4.mhit", 64'(mhit), 64'd1);
        check_eq("mh4.val",  64'(val),  64'd0);
        drive(1'b0, 4'b0000, '0, '0, 2'd0);
        step();
        check_eq("pulse_end.icmiss", 64'(icmiss), 64'd0);
        check_eq("pulse_end.mhit",   64'(mhit),   64'd0);
        check_eq("pulse_end.val",    64'(val),    64'd0);

        // 5. parity: single flipped bit in top word
        ready   = 1'b0;
        wa      = mkw(32'h0f0f_1234, 1'b0);
        bad_top = mkw(32'h5555_0000, 1'b0) ^ 34'h0_0000_0100;
        drive(1'b1, 4'b0100, wa, bad_top, 2'd2);
        step();
        check_head("perr", 1'b1, wa, bad_top, 2'd2, 1'b1);
        ready = 1'b1;
        wb    = mkw(32'h0f0f_5678, 1'b1);
        drive(1'b1, 4'b0100, wb, wb, 2'd1);
        step();
        check_head("perr_ok", 1'b1, wb, wb, 2'd1, 1'b0);
        drive(1'b0, 4'b0000, '0, '0, 2'd0);
        step();
        check_eq("perr_drain.val", 64'(val), 64'd0);

        // 6. flush while full, with a fetch presented
        ready = 1'b0;
        drive(1'b1, 4'b0100, wa, wa, 2'd0);
        step();
        drive(1'b1, 4'b0100, wb, wb, 2'd1);
        step();
        check_eq("fl_full.stall", 64'(stall), 64'd1);
        flush = 1'b1;
        drive(1'b1, 4'b0100, wc, wc, 2'd3);
        step();
        check_eq("fl.val",   64'(val),   64'd0);
        check_eq("fl.stall", 64'(stall), 64'd0);
        check_eq("fl.perr",  64'(perr),  64'd0);
        drive(1'b1, 4'b0000, wc, wc, 2'd3);
        step();
        check_eq("fl_miss.icmiss", 64'(icmiss), 64'd0);
        check_eq("fl_miss.val",    64'(val),    64'd0);
        flush = 1'b0;
        drive(1'b0, 4'b0000, '0, '0, 2'd0);
        step();
        check_eq("fl_after.val",   64'(val),   64'd0);
        check_eq("fl_after.stall", 64'(stall), 64'd0);
        // Queue is usable again after flush.
        drive(1'b1, 4'b0001, wc, wc, 2'd3);
        step();
        check_head("fl_reuse", 1'b1, wc, wc, 2'd3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
